// File: rtl/alu_pkg.sv
// Shared ALU definitions: control-code encoding from the decoder and the
// occupancy states of the execute-stage skid buffer.
package alu_pkg;

  typedef logic [2:0] alu_code_t;

  localparam alu_code_t ALU_ADD = 3'b000;
  localparam alu_code_t ALU_SUB = 3'b001;
  localparam alu_code_t ALU_AND = 3'b010;
  localparam alu_code_t ALU_OR  = 3'b011;
  localparam alu_code_t ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } occ_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: decodes the 3-bit control code and produces the
// result, a zero flag and an illegal-code flag.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_code_t        control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  always_comb begin
    // NOTE: defaults first so every path assigns every output; a missing
    // assignment on any branch would otherwise infer a latch.
    result  = '0;
    illegal = 1'b0;
    case (control)
      ALU_ADD: result = a + b;
      ALU_SUB: result = a - b;
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: illegal = 1'b1;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/alu_exec_stage.sv
// Registered execute stage: ALU result, flags and tag captured as one entry
// in a two-entry skid buffer (OUT + SKID) with a registered in_ready.
module alu_exec_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_code_t        alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal,
  output logic [TAG_W-1:0] out_tag
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  logic [WIDTH-1:0] core_result;
  logic             core_zero;
  logic             core_illegal;
  entry_t           new_entry;
  entry_t           out_q, out_d;
  entry_t           skid_q, skid_d;
  occ_t             state_q, state_d;
  logic             in_ready_q;
  logic             accept;
  logic             drain;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .control (alu_control),
    .a       (src_a),
    .b       (src_b),
    .result  (core_result),
    .zero    (core_zero),
    .illegal (core_illegal)
  );

  assign new_entry = '{result: core_result, zero: core_zero,
                       illegal: core_illegal, tag: in_tag};

  assign accept = in_valid && in_ready_q;
  assign drain  = (state_q != ST_EMPTY) && out_ready;

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_d = ST_ONE;
            out_d   = new_entry;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            out_d = new_entry;
          end else if (accept) begin
            state_d = ST_FULL;
            skid_d  = new_entry;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a drain can move the state
          if (drain) begin
            state_d = ST_ONE;
            out_d   = skid_q;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset as well as the state, because the
      // presented result/flags/tag must read zero straight out of reset.
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_q      <= '0;
      skid_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
      out_q      <= out_d;
      skid_q     <= skid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != ST_EMPTY);
  assign result    = out_q.result;
  assign zero      = out_q.zero;
  assign illegal   = out_q.illegal;
  assign out_tag   = out_q.tag;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: directed scenarios plus random
// traffic compared against a queue-based model of the stage.
module tb_alu_exec_stage;

  localparam int WIDTH = 32;
  localparam int TAG_W = 5;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_control;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             illegal;
  logic [TAG_W-1:0] out_tag;

  alu_exec_stage #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal),
    .out_tag     (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             ill;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t model_q[$];
  int   checks = 0;
  int   errors = 0;
  logic last_acc;

  function automatic exp_t ref_entry(input logic [2:0] c, input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b, input logic [TAG_W-1:0] t);
    exp_t e;
    e.ill = 1'b0;
    case (c)
      3'd0: e.res = a + b;
      3'd1: e.res = a - b;
      3'd2: e.res = a & b;
      3'd3: e.res = a | b;
      3'd5: e.res = ($signed(a) < $signed(b)) ? 1 : 0;
      default: begin
        e.res = 0;
        e.ill = 1'b1;
      end
    endcase
    e.z   = (e.res == 0);
    e.tag = t;
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".in_ready"}, 64'(in_ready), 64'(model_q.size() < 2));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(model_q.size() > 0));
    if (model_q.size() > 0) begin
      check({tag, ".result"}, 64'(result), 64'(model_q[0].res));
      check({tag, ".zero"}, 64'(zero), 64'(model_q[0].z));
      check({tag, ".illegal"}, 64'(illegal), 64'(model_q[0].ill));
      check({tag, ".tag"}, 64'(out_tag), 64'(model_q[0].tag));
    end
  endtask

  // Called at a negedge: drive inputs, advance one clock, update the model,
  // then compare at the following negedge.
  task automatic step(input string tag, input logic v, input logic [2:0] c,
                      input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [TAG_W-1:0] t, input logic ordy, input logic fl);
    logic acc, drn;
    in_valid    = v;
    alu_control = c;
    src_a       = a;
    src_b       = b;
    in_tag      = t;
    out_ready   = ordy;
    flush       = fl;
    acc = v && (model_q.size() < 2);
    drn = ordy && (model_q.size() > 0);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (drn) void'(model_q.pop_front());
      if (acc) model_q.push_back(ref_entry(c, a, b, t));
    end
    @(negedge clk);
    last_acc = acc && !fl;
    check_outputs(tag);
  endtask

  task automatic idle(input string tag, input logic ordy);
    step(tag, 1'b0, 3'd0, '0, '0, '0, ordy, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; alu_control = '0;
    src_a = '0; src_b = '0; in_tag = '0; out_ready = 1'b0;
    last_acc = 1'b0;
    repeat (2) @(negedge clk);
    check("reset.out_valid", 64'(out_valid), 64'd0);
    check("reset.in_ready", 64'(in_ready), 64'd1);
    check("reset.result", 64'(result), 64'd0);
    check("reset.flags", 64'({zero, illegal}), 64'd0);
    check("reset.tag", 64'(out_tag), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // add 5+7: visible one cycle after accept
    step("add", 1'b1, 3'd0, 32'd5, 32'd7, 5'd1, 1'b0, 1'b0);
    check("add.value", 64'(result), 64'd12);
    check("add.zero", 64'(zero), 64'd0);
    idle("add_drain", 1'b1);

    // sub 3-3 then slt -1<1 back to back, full throughput
    step("sub", 1'b1, 3'd1, 32'd3, 32'd3, 5'd2, 1'b1, 1'b0);
    check("sub.zero", 64'(zero), 64'd1);
    step("slt", 1'b1, 3'd5, 32'hFFFF_FFFF, 32'd1, 5'd3, 1'b1, 1'b0);
    check("slt.value", 64'(result), 64'd1);
    check("slt.tag", 64'(out_tag), 64'd3);
    idle("slt_drain", 1'b1);

    // backpressure: two accepted, third waits for in_ready
    step("bp1", 1'b1, 3'd2, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd4, 1'b0, 1'b0);
    step("bp2", 1'b1, 3'd3, 32'h1000_0000, 32'h0000_0001, 5'd5, 1'b0, 1'b0);
    check("bp2.in_ready_low", 64'(in_ready), 64'd0);
    step("bp3_blocked", 1'b1, 3'd0, 32'd100, 32'd23, 5'd6, 1'b0, 1'b0);
    check("bp3.not_accepted", 64'(last_acc), 64'd0);
    begin
      int budget = 10;
      do begin
        step("bp3_release", 1'b1, 3'd0, 32'd100, 32'd23, 5'd6, 1'b1, 1'b0);
        budget--;
      end while (!last_acc && budget > 0);
      check("bp3.accepted_in_time", 64'(last_acc), 64'd1);
    end
    in_valid = 1'b0;
    repeat (3) idle("bp_drain", 1'b1);

    // undefined code, then a legal op clears illegal
    step("illegal", 1'b1, 3'd7, 32'd9, 32'd9, 5'd7, 1'b1, 1'b0);
    check("illegal.flags", 64'({result, zero, illegal}), 64'({32'd0, 1'b1, 1'b1}));
    step("legal_after", 1'b1, 3'd0, 32'd1, 32'd1, 5'd8, 1'b1, 1'b0);
    check("legal_after.illegal", 64'(illegal), 64'd0);
    idle("illegal_drain", 1'b1);

    // fill, then flush with an input offered: everything discarded
    step("fill1", 1'b1, 3'd0, 32'd11, 32'd0, 5'd9, 1'b0, 1'b0);
    step("fill2", 1'b1, 3'd0, 32'd22, 32'd0, 5'd10, 1'b0, 1'b0);
    step("flush", 1'b1, 3'd0, 32'd33, 32'd0, 5'd11, 1'b0, 1'b1);
    check("flush.out_valid", 64'(out_valid), 64'd0);
    check("flush.in_ready", 64'(in_ready), 64'd1);
    repeat (3) idle("post_flush", 1'b1);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] b;
      logic [WIDTH-1:0] a;
      b = $urandom;
      a = ($urandom_range(0, 3) == 0) ? b : $urandom;
      step("rand", 1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), a, b,
           TAG_W'($urandom), 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));
    end

    // asynchronous reset with both entries occupied
    step("pre_rst1", 1'b1, 3'd3, 32'hDEAD_0000, 32'h0000_BEEF, 5'd12, 1'b0, 1'b0);
    step("pre_rst2", 1'b1, 3'd0, 32'd40, 32'd2, 5'd13, 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst.out_valid", 64'(out_valid), 64'd0);
    check("async_rst.in_ready", 64'(in_ready), 64'd1);
    check("async_rst.result", 64'(result), 64'd0);
    check("async_rst.flags", 64'({zero, illegal}), 64'd0);
    check("async_rst.tag", 64'(out_tag), 64'd0);
    model_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    idle("after_rst", 1'b1);
    step("after_rst_op", 1'b1, 3'd1, 32'd10, 32'd4, 5'd14, 1'b1, 1'b0);
    idle("final_drain", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
